// File: rtl/icache_fetch.sv
`default_nettype none
// ============================================================================
// Module   : icache_fetch
// Brief    : Direct-mapped, one-word-per-line instruction cache between the
//            fetch stage and the memory IO controller instruction port.
// Revision : 1.0
// ============================================================================

module icache_fetch #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 30 - INDEX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        if_en_i,
    input  logic [31:0] if_pc_i,
    output logic        if_en_o,
    output logic [31:0] if_ins_o,
    output logic        mc_en_o,
    output logic [31:0] mc_pc_o,
    input  logic        mc_en_i,
    input  logic [31:0] mc_ins_i,
    input  logic        br_flag,
    input  logic        inv_i
);

    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        REQ    = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         preg_q, preg_d;
    logic                if_en_q, if_en_d;
    logic [31:0]         if_ins_q, if_ins_d;
    logic                mc_en_q, mc_en_d;
    logic [31:0]         mc_pc_q, mc_pc_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_ptag;
    logic                w_hit;
    logic                w_fill;

    assign w_idx  = preg_q[INDEX_W+1:2];
    assign w_ptag = preg_q[31:2+INDEX_W];
    assign w_hit  = valid_q[w_idx] && (tag_q[w_idx] == w_ptag);
    // A flush discards a response arriving in the same cycle.
    assign w_fill = en && !br_flag && (state_q == WAIT) && mc_en_i;

    always_comb begin
        state_d  = state_q;
        preg_d   = preg_q;
        if_en_d  = 1'b0;
        if_ins_d = if_ins_q;
        mc_en_d  = 1'b0;
        mc_pc_d  = mc_pc_q;
        if (br_flag) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_en_i) begin
                        preg_d  = if_pc_i;
                        state_d = LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        if_en_d  = 1'b1;
                        if_ins_d = data_q[w_idx];
                        state_d  = IDLE;
                    end else begin
                        mc_en_d = 1'b1;
                        mc_pc_d = preg_q;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (mc_en_i) begin
                        if_en_d  = 1'b1;
                        if_ins_d = mc_ins_i;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Invalidate first so a coincident fill keeps its own line valid.
    always_comb begin
        valid_d = valid_q;
        if (inv_i) begin
            valid_d = '0;
        end
        if (w_fill) begin
            valid_d[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            preg_q   <= '0;
            if_en_q  <= 1'b0;
            if_ins_q <= '0;
            mc_en_q  <= 1'b0;
            mc_pc_q  <= '0;
            valid_q  <= '0;
        end else if (en) begin
            state_q  <= state_d;
            preg_q   <= preg_d;
            if_en_q  <= if_en_d;
            if_ins_q <= if_ins_d;
            mc_en_q  <= mc_en_d;
            mc_pc_q  <= mc_pc_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_fill) begin
            tag_q[w_idx]  <= w_ptag;
            data_q[w_idx] <= mc_ins_i;
        end
    end

    assign if_en_o  = if_en_q && en;
    assign mc_en_o  = mc_en_q && en;
    assign if_ins_o = if_ins_q;
    assign mc_pc_o  = mc_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_icache_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_fetch
// Brief    : Self-checking bench for icache_fetch with a response scoreboard.
// Revision : 1.0
// ============================================================================

module tb_icache_fetch;

    logic        clk = 1'b0;
    logic        rst, en, if_en_i, mc_en_i, br_flag, inv_i;
    logic [31:0] if_pc_i, mc_ins_i;
    logic        if_en_o, mc_en_o;
    logic [31:0] if_ins_o, mc_pc_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] exp_ins_q[$];
    logic [31:0] exp_mc_q[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] exp_ins;
        bit          miss;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    icache_fetch #(.INDEX_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .if_en_i  (if_en_i),
        .if_pc_i  (if_pc_i),
        .if_en_o  (if_en_o),
        .if_ins_o (if_ins_o),
        .mc_en_o  (mc_en_o),
        .mc_pc_o  (mc_pc_o),
        .mc_en_i  (mc_en_i),
        .mc_ins_i (mc_ins_i),
        .br_flag  (br_flag),
        .inv_i    (inv_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] backing(input logic [31:0] pc);
        return (pc == 32'h10) ? 32'h0051_0113 : (pc ^ 32'h5A5A_0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        logic [31:0] e;
        if (if_en_o === 1'b1) begin
            checks++;
            if (exp_ins_q.size() == 0) begin
                errors++;
                $display("FAIL if_en_o unexpected: got ins %h, required no pulse", if_ins_o);
            end else begin
                e = exp_ins_q.pop_front();
                if (if_ins_o !== e) begin
                    errors++;
                    $display("FAIL if_ins_o: got %h, required %h", if_ins_o, e);
                end
            end
        end
        if (mc_en_o === 1'b1) begin
            checks++;
            if (exp_mc_q.size() == 0) begin
                errors++;
                $display("FAIL mc_en_o unexpected: got pc %h, required no pulse", mc_pc_o);
            end else begin
                e = exp_mc_q.pop_front();
                if (mc_pc_o !== e) begin
                    errors++;
                    $display("FAIL mc_pc_o: got %h, required %h", mc_pc_o, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] exp_ins,
                            input bit miss, input int lat, input bit inv_fill,
                            input string name);
        int t0;
        bit saw_mc = 1'b0;
        bit done   = 1'b0;
        step();
        if_en_i = 1'b1;
        if_pc_i = pc;
        t0      = cyc;
        if (miss) exp_mc_q.push_back(pc);
        exp_ins_q.push_back(exp_ins);
        step();
        if_en_i = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            if (mc_en_o && !saw_mc) begin
                saw_mc = 1'b1;
                chk({name, " mc_lat"}, 32'(cyc - t0), 32'd2);
                repeat (lat) step();
                mc_en_i  = 1'b1;
                mc_ins_i = backing(pc);
                inv_i    = inv_fill;
                step();
                mc_en_i  = 1'b0;
                mc_ins_i = 32'h0;
                inv_i    = 1'b0;
            end
            if (if_en_o) begin
                done = 1'b1;
                chk({name, " if_lat"}, 32'(cyc - t0), miss ? 32'(3 + lat) : 32'd2);
            end else begin
                step();
            end
        end
        chk({name, " done"}, {31'b0, done}, 32'd1);
        chk({name, " miss"}, {31'b0, saw_mc}, {31'b0, miss});
    endtask

    task automatic abort_fetch(input logic [31:0] pc, input bit coincident, input string name);
        bit seen = 1'b0;
        step();
        if_en_i = 1'b1;
        if_pc_i = pc;
        exp_mc_q.push_back(pc);
        step();
        if_en_i = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (mc_en_o) seen = 1'b1;
            else step();
        end
        chk({name, " req"}, {31'b0, seen}, 32'd1);
        repeat (2) step();
        if (coincident) begin
            mc_en_i  = 1'b1;
            mc_ins_i = backing(pc);
            br_flag  = 1'b1;
            step();
            mc_en_i  = 1'b0;
            br_flag  = 1'b0;
        end else begin
            br_flag = 1'b1;
            step();
            br_flag = 1'b0;
            step();
            mc_en_i  = 1'b1;
            mc_ins_i = 32'hDEAD_BEEF;
            step();
            mc_en_i  = 1'b0;
        end
        mc_ins_i = 32'h0;
        repeat (4) begin
            step();
            chk({name, " no if_en_o"}, {31'b0, if_en_o}, 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0010, 32'h0051_0113, 1'b1, 5};
        vecs[1]  = '{32'h0000_0010, 32'h0051_0113, 1'b0, 0};
        vecs[2]  = '{32'h0000_0000, 32'h5A5A_0000, 1'b1, 3};
        vecs[3]  = '{32'h0000_0100, 32'h5A5A_0100, 1'b1, 2};
        vecs[4]  = '{32'h0000_0000, 32'h5A5A_0000, 1'b1, 4};
        vecs[5]  = '{32'h0000_0104, 32'h5A5A_0104, 1'b1, 1};
        vecs[6]  = '{32'h0000_0000, 32'h5A5A_0000, 1'b0, 0};
        vecs[7]  = '{32'h0000_0104, 32'h5A5A_0104, 1'b0, 0};
        vecs[8]  = '{32'h0000_00FC, 32'h5A5A_00FC, 1'b1, 1};
        vecs[9]  = '{32'h0000_00FC, 32'h5A5A_00FC, 1'b0, 0};
        vecs[10] = '{32'h0800_00FC, 32'h525A_00FC, 1'b1, 2};
        vecs[11] = '{32'h0000_00FC, 32'h5A5A_00FC, 1'b1, 1};

        rst = 1'b1; en = 1'b1; if_en_i = 1'b0; if_pc_i = '0;
        mc_en_i = 1'b0; mc_ins_i = '0; br_flag = 1'b0; inv_i = 1'b0;
        repeat (3) step();
        chk("reset if_en_o",  {31'b0, if_en_o}, 32'd0);
        chk("reset mc_en_o",  {31'b0, mc_en_o}, 32'd0);
        chk("reset if_ins_o", if_ins_o, 32'd0);
        chk("reset mc_pc_o",  mc_pc_o, 32'd0);
        rst = 1'b0;

        foreach (vecs[i])
            do_fetch(vecs[i].pc, vecs[i].exp_ins, vecs[i].miss, vecs[i].lat, 1'b0,
                     $sformatf("vec%0d", i));

        abort_fetch(32'h40, 1'b1, "br_coincident");
        abort_fetch(32'h40, 1'b0, "br_late");
        do_fetch(32'h40, 32'h5A5A_0040, 1'b1, 2, 1'b0, "refetch_40");

        do_fetch(32'h20, 32'h5A5A_0020, 1'b1, 1, 1'b0, "fill_20");
        do_fetch(32'h20, 32'h5A5A_0020, 1'b0, 0, 1'b0, "hit_20");
        step(); inv_i = 1'b1; step(); inv_i = 1'b0;
        do_fetch(32'h20, 32'h5A5A_0020, 1'b1, 3, 1'b0, "inv_20");
        do_fetch(32'h24, 32'h5A5A_0024, 1'b1, 2, 1'b1, "inv_fill_24");
        do_fetch(32'h24, 32'h5A5A_0024, 1'b0, 0, 1'b0, "hit_24");
        do_fetch(32'h20, 32'h5A5A_0020, 1'b1, 1, 1'b0, "cleared_20");

        // Reset while waiting on the controller.
        step();
        if_en_i = 1'b1; if_pc_i = 32'h30;
        exp_mc_q.push_back(32'h30);
        step();
        if_en_i = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid if_en_o",  {31'b0, if_en_o}, 32'd0);
        chk("rst_mid mc_en_o",  {31'b0, mc_en_o}, 32'd0);
        chk("rst_mid if_ins_o", if_ins_o, 32'd0);
        chk("rst_mid mc_pc_o",  mc_pc_o, 32'd0);
        do_fetch(32'h30, 32'h5A5A_0030, 1'b1, 2, 1'b0, "after_rst_30");
        do_fetch(32'h10, 32'h0051_0113, 1'b1, 1, 1'b0, "after_rst_10");
        do_fetch(32'h10, 32'h0051_0113, 1'b0, 0, 1'b0, "after_rst_hit10");

        // A fetch request while disabled must be ignored entirely.
        step();
        en = 1'b0; if_en_i = 1'b1; if_pc_i = 32'h10;
        step();
        if_en_i = 1'b0;
        repeat (3) begin
            step();
            chk("en0 if_en_o", {31'b0, if_en_o}, 32'd0);
        end
        en = 1'b1;
        repeat (3) begin
            step();
            chk("en1 idle if_en_o", {31'b0, if_en_o}, 32'd0);
        end
        do_fetch(32'h30, 32'h5A5A_0030, 1'b0, 0, 1'b0, "hit_30");

        repeat (3) step();
        chk("ins queue empty", 32'(exp_ins_q.size()), 32'd0);
        chk("mc queue empty",  32'(exp_mc_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/icache_fetch.md
# icache_fetch

Direct-mapped, one-word-per-line instruction cache sitting between the fetch stage and the memory IO controller. It acts as the initiator on the controller's instruction port. On a hit it returns the 32-bit instruction itself. On a miss it issues a fetch request to the controller, waits for the assembled word, fills the line and forwards the word. It honours the pipeline's branch flush by abandoning any in-flight miss.

## Interface
Parameters:
- INDEX_W, 6, index bits; the cache holds 2^INDEX_W lines of 32 bits each.
- TAG_W, 30-INDEX_W, tag bits, taken from pc[31:2+INDEX_W].

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global enable; when 0, all state holds and output pulses are held at 0.
- if_en_i  in  1  one-cycle fetch request pulse from the fetch stage.
- if_pc_i  in  32  fetch address; bits [1:0] must be 00.
- if_en_o  out  1  one-cycle pulse: if_ins_o is valid.
- if_ins_o  out  32  fetched instruction; holds its last value between pulses.
- mc_en_o  out  1  one-cycle request pulse to the controller's instruction port.
- mc_pc_o  out  32  request address; held stable from the request until the response or abort.
- mc_en_i  in  1  one-cycle completion pulse from the controller.
- mc_ins_i  in  32  word returned by the controller; valid only while mc_en_i is high.
- br_flag  in  1  branch flush: abort the outstanding fetch.
- inv_i  in  1  invalidate all lines (fence.i).

## Operation
- Storage:
  - valid[2^INDEX_W] is a flop array.
  - tag and data are register arrays indexed by pc[INDEX_W+1:2].
- States:
  - IDLE, LOOKUP, REQ, WAIT.
  - Encoded in 2 bits; reset state is IDLE.
- IDLE:
  - if_en_i latches the pc into preg and moves to LOOKUP.
  - if_en_i in any other state is ignored; the fetch stage never issues while a request is outstanding.
- LOOKUP:
  - Hit means valid[idx] && tag[idx]==preg tag.
  - Hit: pulse if_en_o and drive if_ins_o=data[idx]; go to IDLE.
  - Miss: go to REQ.
- REQ:
  - Pulse mc_en_o with mc_pc_o=preg; go to WAIT.
- WAIT:
  - On mc_en_i, write data[idx]=mc_ins_i, tag[idx]=preg tag, valid[idx]=1.
  - In the same edge, drive if_ins_o=mc_ins_i and pulse if_en_o; go to IDLE.
- br_flag, from any state: priority over every other event.
  - Next state is IDLE; no if_en_o or mc_en_o pulse is produced.
  - An mc_en_i arriving in the br_flag cycle is discarded and its line is not filled.
  - if_en_i in the br_flag cycle is ignored; the fetch stage reissues the redirected pc next cycle.
- inv_i:
  - Clears all valid bits at the edge.
  - If it coincides with a WAIT fill, the fill is still written, with valid=1 (fill wins for that line).
  - inv_i does not change the FSM state.
- Stale response:
  - mc_en_i in IDLE, LOOKUP or REQ is ignored.
- Reset (asserted in any state, including mid-WAIT):
  - state=IDLE, valid all 0.
  - if_en_o=0, mc_en_o=0, if_ins_o=0, mc_pc_o=0, preg=0.
  - Tag and data arrays are not reset.

## Timing
- Hit latency: if_en_i in cycle T gives if_en_o in cycle T+2 (registered LOOKUP result).
- Miss: if_en_i at T, mc_en_o at T+2, controller responds at T+2+N, if_en_o at T+3+N.
- Handshake pulses:
  - if_en_o and mc_en_o are registered and high for exactly one cycle per transaction.
  - Back-to-back fetches: earliest next if_en_i is in the cycle of if_en_o.
- mc_pc_o changes only on the REQ transition.
- When en=0:
  - FSM, arrays and preg are frozen.
  - Pulse outputs read 0.
  - An mc_en_i pulse arriving during en=0 is lost; the controller shares the same en, so this does not occur.

## Test plan
- Cold miss then hit:
  - Reset, then if_en_i pc=0x0000_0010; controller returns 0x0051_0113 after 5 cycles.
  - Required: mc_en_o once with mc_pc_o=0x10, then if_en_o with 0x0051_0113.
  - Repeat pc=0x10: if_en_o 2 cycles later, no mc_en_o.
- Conflict eviction (INDEX_W=6):
  - Fetch 0x0000_0000, then 0x0000_0100 (same index, new tag), then 0x0000_0000.
  - Required: three controller requests; the third fetch returns the original word.
- Branch abort:
  - Miss on 0x40; assert br_flag 2 cycles into WAIT; controller emits a late mc_en_i (0xDEAD_BEEF).
  - Required: no if_en_o; a later fetch of 0x40 misses again.
- br_flag coincident with mc_en_i:
  - Required: no if_en_o; valid[0x40 idx] stays 0.
- Invalidate:
  - Fill 0x20; pulse inv_i; fetch 0x20.
  - Required: miss, mc_en_o reissued.
  - inv_i on the same edge as a fill of 0x24: a subsequent 0x24 fetch hits.
- Reset mid-miss:
  - rst during WAIT.
  - Required: all outputs 0 next cycle; a following fetch of the same pc misses.
